// File: rtl/hier_rr_arbiter_if.sv
// hier_rr_arbiter_if: request/grant bundle between a hierarchy level's
// requesters (master side) and the shared-resource arbiter (slave side).
interface hier_rr_arbiter_if #(
    parameter int N_REQ = 15,
    parameter int ID_W  = 5
) ();
    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;
    logic             timeout_pulse;

    modport master (
        output en, req,
        input  gnt, gnt_valid, gnt_id, timeout_pulse
    );

    modport slave (
        input  en, req,
        output gnt, gnt_valid, gnt_id, timeout_pulse
    );
endinterface

// File: rtl/hier_rr_arbiter.sv
// hier_rr_arbiter: round-robin arbiter sharing one downstream resource among
// N_REQ sibling requesters. Registered one-hot grant held until the owner drops
// its request, followed by exactly one dead (RECOVER) cycle before the next
// owner. Optional forced release after MAX_HOLD cycles is compiled in when the
// macro HIER_ARB_TIMEOUT_EN is defined; otherwise timeout_pulse is tied low.
module hier_rr_arbiter #(
    parameter int N_REQ    = 15,
    parameter int ID_W     = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hier_rr_arbiter_if.slave     arb
);

    // Elaboration-time parameter legality checks.
    if (N_REQ < 2 || N_REQ > 32) begin : g_bad_n_req
        $error("hier_rr_arbiter: N_REQ must be in 2..32");
    end
    if ((1 << ID_W) < N_REQ) begin : g_bad_id_w
        $error("hier_rr_arbiter: ID_W too narrow for N_REQ");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("hier_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
`ifdef HIER_ARB_TIMEOUT_EN
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    logic [N_REQ-1:0] upper_mask;
    logic [N_REQ-1:0] masked_req;
    logic [N_REQ-1:0] pool;
    logic [N_REQ-1:0] win_vec;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  next_ptr;
    logic             owner_req;
    logic             can_grant;

    // Bits at or above the priority pointer form the first search window.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign upper_mask[gi] = (ID_W'(gi) >= ptr_q);
    end

    // Circular search: lowest set request at/after ptr, else lowest overall.
    always_comb begin
        masked_req = arb.req & upper_mask;
        pool       = (|masked_req) ? masked_req : arb.req;
        win_vec    = pool & (~pool + N_REQ'(1));
        win_id     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // The owner's request is picked out with the one-hot grant itself.
    assign owner_req = |(arb.req & gnt_q);
    assign can_grant = arb.en && (|arb.req);
    assign next_ptr  = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);

    // Next-state and next-grant decision for the three-state controller.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
`ifdef HIER_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_RECOVER: begin
                if (can_grant) begin
                    state_d  = S_GRANT;
                    gnt_d    = win_vec;
                    gnt_id_d = win_id;
`ifdef HIER_ARB_TIMEOUT_EN
                    hold_cnt_d = 8'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
`ifdef HIER_ARB_TIMEOUT_EN
                if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
`endif
                if (!owner_req) begin
                    state_d = S_RECOVER;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                end
`ifdef HIER_ARB_TIMEOUT_EN
                else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
                    state_d   = S_RECOVER;
                    gnt_d     = '0;
                    ptr_d     = next_ptr;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and grant registers; reset clears any grant immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
`ifdef HIER_ARB_TIMEOUT_EN
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
`ifdef HIER_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_valid = |gnt_q;
    assign arb.gnt_id    = gnt_id_q;
`ifdef HIER_ARB_TIMEOUT_EN
    assign arb.timeout_pulse = timeout_q;
`else
    assign arb.timeout_pulse = 1'b0;
`endif

endmodule
